button_conditioner: RTL

//   Input stage between the board's raw push-buttons/switches and the free-play mode controller.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/debounce_cell.sv | 50 +++++
 rtl/button_conditioner.sv | 103 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: channel counts and nav channel indices.
// Nav channels follow the note keys in the flat per-channel vectors used by the top.
package btn_pkg;

    localparam int NUM_KEYS = 8;
    localparam int NUM_NAV  = 3;
    localparam int NUM_CH   = NUM_KEYS + NUM_NAV;

    localparam int NAV_UP     = 0;
    localparam int NAV_CENTER = 1;
    localparam int NAV_DOWN   = 2;

    typedef logic [NUM_NAV-1:0]  nav_vec_t;
    typedef logic [NUM_KEYS-1:0] key_vec_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced channel: 2-flop synchroniser, hold counter, accepted level and a
// registered rise pulse that appears in the cycle after the level goes 0->1.
module debounce_cell #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_nxt,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          level_q;

    // The next level is exposed so the top can register derived flags in step with it.
    always_comb begin
        level_nxt = level;
        if (s2 != level && cnt == LAST)
            level_nxt = s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            level   <= level_nxt;
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces 8 note keys and 3 nav buttons; emits key levels, press pulses and nav pulses.
// Build with NAV_AUTOREPEAT_EN defined to add hold-to-repeat on the nav pulses.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys_raw,
    input  logic       btn_up_raw,
    input  logic       btn_center_raw,
    input  logic       btn_down_raw,
    output logic [7:0] keys,
    output logic [7:0] keys_press,
    output logic       any_key,
    output logic       up_pulse,
    output logic       center_pulse,
    output logic       down_pulse
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] level_nxt;
    logic [NUM_CH-1:0] rise;
    nav_vec_t          nav_level;
    nav_vec_t          nav_pulse;

    assign raw[NUM_KEYS-1:0]       = keys_raw;
    assign raw[NUM_KEYS+NAV_UP]     = btn_up_raw;
    assign raw[NUM_KEYS+NAV_CENTER] = btn_center_raw;
    assign raw[NUM_KEYS+NAV_DOWN]   = btn_down_raw;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_cell #(
            .DB_CYCLES(DB_CYCLES)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .raw       (raw[i]),
            .level     (level[i]),
            .level_nxt (level_nxt[i]),
            .rise      (rise[i])
        );
    end

    assign keys       = level[NUM_KEYS-1:0];
    assign keys_press = rise[NUM_KEYS-1:0];
    assign nav_level  = level[NUM_KEYS +: NUM_NAV];

    // Registered from the next levels so any_key changes in the same cycle as keys.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            any_key <= 1'b0;
        else
            any_key <= |level_nxt[NUM_KEYS-1:0];
    end

`ifdef NAV_AUTOREPEAT_EN
    localparam int HW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [NUM_NAV-1:0][HW-1:0] hold;
    nav_vec_t                   rep_mode;
    nav_vec_t                   rep;

    // hold counts cycles of a held nav level; first target is the delay, then the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            rep_mode <= '0;
            rep      <= '0;
        end else begin
            for (int j = 0; j < NUM_NAV; j++) begin
                rep[j] <= 1'b0;
                if (!nav_level[j]) begin
                    hold[j]     <= '0;
                    rep_mode[j] <= 1'b0;
                end else if (!rep_mode[j] && hold[j] == HW'(REPEAT_DELAY)) begin
                    rep[j]      <= 1'b1;
                    rep_mode[j] <= 1'b1;
                    hold[j]     <= HW'(1);
                end else if (rep_mode[j] && hold[j] == HW'(REPEAT_PERIOD)) begin
                    rep[j]  <= 1'b1;
                    hold[j] <= HW'(1);
                end else begin
                    hold[j] <= hold[j] + HW'(1);
                end
            end
        end
    end

    assign nav_pulse = rise[NUM_KEYS +: NUM_NAV] | rep;
`else
    assign nav_pulse = rise[NUM_KEYS +: NUM_NAV];
`endif

    assign up_pulse     = nav_pulse[NAV_UP];
    assign center_pulse = nav_pulse[NAV_CENTER];
    assign down_pulse   = nav_pulse[NAV_DOWN];

endmodule
